// File: rtl/balance_tree_adder_if.sv
// Data bundle for the balanced adder tree: the packed element vector in and
// the registered, zero-extended sum out.
interface balance_tree_adder_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [(2**N)*DW-1:0] inp;
    logic [DW*N-1:0]      outp;

    modport master (output inp, input outp);
    modport slave  (input inp, output outp);
endinterface

// File: rtl/balance_tree_adder.sv
// Pipelined balanced binary adder tree: N registered levels reduce 2**N
// unsigned DW-bit elements to one full-precision sum, one vector per clock.
module balance_tree_adder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    balance_tree_adder_if.slave  bus
);

    // Level k holds 2**(N-k) sums, each one bit wider than its operands.
    for (genvar k = 1; k <= N; k++) begin : g_lvl
        localparam int CNT = 2**(N-k);
        logic [DW+k-1:0] sum [CNT];

        if (k == 1) begin : g_leaf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < CNT; j++) begin
                        sum[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < CNT; j++) begin
                        sum[j] <= {1'b0, bus.inp[(2*j)*DW +: DW]}
                                + {1'b0, bus.inp[(2*j+1)*DW +: DW]};
                    end
                end
            end
        end else begin : g_node
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < CNT; j++) begin
                        sum[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < CNT; j++) begin
                        sum[j] <= {1'b0, g_lvl[k-1].sum[2*j]}
                                + {1'b0, g_lvl[k-1].sum[2*j+1]};
                    end
                end
            end
        end
    end

    assign bus.outp = (DW*N)'(g_lvl[N].sum[0]);

endmodule

// File: tb/tb_balance_tree_adder.sv
// Directed self-checking bench for balance_tree_adder (N=4, DW=8): reset,
// latency, overflow, streaming and mid-operation reset behaviour.
module tb_balance_tree_adder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   sent[$];

    balance_tree_adder_if #(.N(N), .DW(DW)) bus ();

    balance_tree_adder #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: outp=0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input int base, input int step);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[i*8 +: 8] = 8'(base + i*step);
        end
        return v;
    endfunction

    // Drive one vector before the next rising edge and check the sum of the
    // vector sampled three edges earlier (zero while the pipe is filling).
    task automatic applyStimulus(input string tag, input logic [127:0] vec, input int exp_sum);
        logic [31:0] exp;
        @(negedge clk);
        bus.inp = vec;
        sent.push_back(exp_sum);
        @(posedge clk);
        #1;
        exp = (sent.size() >= 4) ? 32'(sent[sent.size()-4]) : 32'd0;
        checkOutput(tag, bus.outp, exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.inp      = '0;

        // Held in reset: random inputs must never reach outp.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.inp = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            checkOutput("reset_hold", bus.outp, 32'd0);
        end

        // Release between edges; the next rising edge is the first sample.
        #1 rst_n = 1'b1;
        sent.delete();
        for (int c = 0; c < 6; c++) begin
            applyStimulus("ramp_0_15", ramp(0, 1), 120);
        end

        for (int c = 0; c < 4; c++) begin
            applyStimulus("all_ff", ramp(255, 0), 4080);
        end

        for (int c = 0; c < 10; c++) begin
            applyStimulus("counter", 128'(32 + c), 32 + c);
        end

        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) applyStimulus("alt_a", ramp(1, 0), 16);
            else            applyStimulus("alt_b", ramp(2, 0), 32);
        end

        // Reset between edges while non-zero sums are in flight.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_clear", bus.outp, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.inp = ramp(9, 3);
            @(posedge clk);
            #1;
            checkOutput("reset_mid_hold", bus.outp, 32'd0);
        end
        #1 rst_n = 1'b1;
        sent.delete();
        applyStimulus("post_reset_a", ramp(3, 0), 48);
        applyStimulus("post_reset_b", ramp(0, 2), 240);
        applyStimulus("post_reset_c", ramp(10, 1), 280);
        applyStimulus("post_reset_d", ramp(3, 0), 48);
        applyStimulus("post_reset_e", ramp(0, 0), 0);
        applyStimulus("post_reset_f", ramp(0, 0), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
